// File: rtl/sm_trace_pkg.sv
// Shared definitions for the sm_cpu instruction-trace buffer:
// capture-state encoding and the trace-index width helper.
package sm_trace_pkg;

    typedef enum logic [1:0] {
        TRC_IDLE  = 2'd0,
        TRC_ARMED = 2'd1,
        TRC_POST  = 2'd2,
        TRC_DONE  = 2'd3
    } trc_state_e;

    function automatic int trc_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sm_trace_ram.sv
// Simple dual-port trace storage: synchronous write, registered read.
module sm_trace_ram #(
    parameter int DEPTH = 16,
    parameter int DW    = 64,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // NOTE: the array has no reset so it maps onto RAM macros; only the read register resets.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sm_trace_buf.sv
// Circular trace of committed {pc, instr} pairs with PC trigger, post-trigger window and watchdog.
// Optional: define SM_TRACE_FILTER_NOP_EN to drop commits whose instruction word is zero.
module sm_trace_buf
    import sm_trace_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32,
    parameter int POST    = 4,
    parameter int TIMEOUT = 240,
    parameter int CYC_W   = 16,
    localparam int AW     = trc_idx_w(DEPTH),
    localparam int DW     = PC_W + INSTR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               arm,
    input  logic [PC_W-1:0]    trig_pc,
    input  logic               commit_valid,
    input  logic [PC_W-1:0]    commit_pc,
    input  logic [INSTR_W-1:0] commit_instr,
    input  logic [AW-1:0]      rd_addr,
    output logic [DW-1:0]      rd_data,
    output logic [AW:0]        count,
    output logic [1:0]         state,
    output logic               triggered,
    output logic               timeout,
    output logic [CYC_W-1:0]   cycle
);

    localparam int              CW      = AW + 1;
    localparam logic [CW-1:0]   FULL    = CW'(DEPTH);
    localparam logic [AW-1:0]   POST_LD = AW'(POST);
    localparam logic [CYC_W-1:0] WD_LAST = CYC_W'(TIMEOUT - 1);

    trc_state_e       r_state, w_state_nx;
    logic [AW-1:0]    r_wr_ptr, w_ptr_nx;
    logic [CW-1:0]    r_count, w_count_nx;
    logic [AW-1:0]    r_post_cnt, w_post_nx;
    logic [CYC_W-1:0] r_cycle, w_cycle_nx;
    logic             r_triggered, w_trig_nx;
    logic             r_timeout, w_tout_nx;
    logic             r_rd_ok;
    logic             w_we, w_commit, w_trig_hit, w_wd_hit, w_rd_ok;
    logic [AW-1:0]    w_oldest, w_rd_idx;
    logic [DW-1:0]    w_ram_q;

`ifdef SM_TRACE_FILTER_NOP_EN
    assign w_commit = commit_valid && (commit_instr != '0);
`else
    assign w_commit = commit_valid;
`endif

    assign w_trig_hit = w_commit && (commit_pc == trig_pc);
    assign w_wd_hit   = (r_cycle == WD_LAST);

    // NOTE: every next-state signal takes its hold value first, so no path can infer a latch.
    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_wr_ptr;
        w_count_nx = r_count;
        w_post_nx  = r_post_cnt;
        w_cycle_nx = r_cycle;
        w_trig_nx  = r_triggered;
        w_tout_nx  = r_timeout;
        w_we       = 1'b0;
        unique case (r_state)
            TRC_IDLE, TRC_DONE: begin
                if (arm) begin
                    w_state_nx = TRC_ARMED;
                    w_ptr_nx   = '0;
                    w_count_nx = '0;
                    w_post_nx  = '0;
                    w_cycle_nx = '0;
                    w_trig_nx  = 1'b0;
                    w_tout_nx  = 1'b0;
                end
            end
            TRC_ARMED, TRC_POST: begin
                if (r_cycle != '1) w_cycle_nx = r_cycle + CYC_W'(1);
                if (w_commit) begin
                    w_we     = 1'b1;
                    w_ptr_nx = r_wr_ptr + AW'(1);
                    if (r_count != FULL) w_count_nx = r_count + CW'(1);
                end
                if (r_state == TRC_ARMED) begin
                    // A trigger on the watchdog's last cycle takes priority over the timeout.
                    if (w_trig_hit) begin
                        w_trig_nx  = 1'b1;
                        w_post_nx  = POST_LD;
                        w_state_nx = (POST == 0) ? TRC_DONE : TRC_POST;
                    end else if (w_wd_hit) begin
                        w_tout_nx  = 1'b1;
                        w_state_nx = TRC_DONE;
                    end
                end else begin
                    if (w_commit) begin
                        w_post_nx = r_post_cnt - AW'(1);
                        if (r_post_cnt == AW'(1)) w_state_nx = TRC_DONE;
                    end
                    if (w_wd_hit) begin
                        w_tout_nx  = 1'b1;
                        w_state_nx = TRC_DONE;
                    end
                end
            end
        endcase
    end

    // Once the buffer has wrapped, the write pointer marks the oldest entry.
    assign w_oldest = (r_count == FULL) ? r_wr_ptr : '0;
    assign w_rd_idx = w_oldest + rd_addr;
    assign w_rd_ok  = (r_state == TRC_DONE) && ({1'b0, rd_addr} < r_count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= TRC_IDLE;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_post_cnt  <= '0;
            r_cycle     <= '0;
            r_triggered <= 1'b0;
            r_timeout   <= 1'b0;
            r_rd_ok     <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_wr_ptr    <= w_ptr_nx;
            r_count     <= w_count_nx;
            r_post_cnt  <= w_post_nx;
            r_cycle     <= w_cycle_nx;
            r_triggered <= w_trig_nx;
            r_timeout   <= w_tout_nx;
            r_rd_ok     <= w_rd_ok;
        end
    end

    sm_trace_ram #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata ({commit_pc, commit_instr}),
        .i_raddr (w_rd_idx),
        .o_rdata (w_ram_q)
    );

    assign rd_data   = r_rd_ok ? w_ram_q : '0;
    assign count     = r_count;
    assign state     = r_state;
    assign triggered = r_triggered;
    assign timeout   = r_timeout;
    assign cycle     = r_cycle;

endmodule

// File: tb/tb_sm_trace_buf.sv
// Scoreboard bench for sm_trace_buf: a main instance (POST=4) and a POST=0 instance share stimulus.
module tb_sm_trace_buf;

    localparam int DEPTH   = 16;
    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int POST    = 4;
    localparam int TIMEOUT = 240;
    localparam int CYC_W   = 16;
    localparam int AW      = 4;
`ifdef SM_TRACE_FILTER_NOP_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               arm = 1'b0;
    logic [PC_W-1:0]    trig_pc = '0;
    logic               commit_valid = 1'b0;
    logic [PC_W-1:0]    commit_pc = '0;
    logic [INSTR_W-1:0] commit_instr = '0;
    logic [AW-1:0]      rd_addr = '0;

    logic [63:0]      rd_data, rd_data0;
    logic [AW:0]      count, count0;
    logic [1:0]       state, state0;
    logic             triggered, triggered0, timeout, timeout0;
    logic [CYC_W-1:0] cycle, cycle0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] model_q[$];
    logic [63:0] exp_q[$];
    bit          m_cap;
    bit          m_in_post;
    int          m_post;
    logic [31:0] m_trig;

    always #5 clk = ~clk;

    sm_trace_buf #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W), .POST(POST),
                   .TIMEOUT(TIMEOUT), .CYC_W(CYC_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .trig_pc(trig_pc),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
        .rd_addr(rd_addr), .rd_data(rd_data), .count(count), .state(state),
        .triggered(triggered), .timeout(timeout), .cycle(cycle));

    sm_trace_buf #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W), .POST(0),
                   .TIMEOUT(TIMEOUT), .CYC_W(CYC_W)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .arm(arm), .trig_pc(trig_pc),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
        .rd_addr(rd_addr), .rd_data(rd_data0), .count(count0), .state(state0),
        .triggered(triggered0), .timeout(timeout0), .cycle(cycle0));

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic do_arm(input logic [31:0] tpc);
        trig_pc = tpc;
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
        model_q.delete();
        m_cap = 1'b1;
        m_in_post = 1'b0;
        m_post = 0;
        m_trig = tpc;
    endtask

    // Drives one commit and updates the reference capture model (POST=4 instance).
    task automatic commit(input logic [31:0] pc, input logic [31:0] instr);
        commit_valid = 1'b1;
        commit_pc = pc;
        commit_instr = instr;
        @(posedge clk); #1;
        commit_valid = 1'b0;
        if (m_cap && !(FILTER && instr == 32'd0)) begin
            model_q.push_back({pc, instr});
            if (model_q.size() > DEPTH) model_q.delete(0);
            if (m_in_post) begin
                m_post--;
                if (m_post == 0) m_cap = 1'b0;
            end else if (pc == m_trig) begin
                m_in_post = 1'b1;
                m_post = POST;
                if (POST == 0) m_cap = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(input int budget, output int edges);
        edges = 0;
        while (state !== 2'd3 && edges < budget) begin
            @(posedge clk); #1;
            edges++;
        end
        if (state !== 2'd3) begin
            n_checks++; n_fail++;
            $display("FAIL wait_done: state %0d after %0d cycles, required 3", state, edges);
        end
    endtask

    task automatic read_all(input int n, input string tag);
        logic [63:0] e;
        for (int i = 0; i < n; i++) begin
            rd_addr = AW'(i);
            exp_q.push_back((i < model_q.size()) ? model_q[i] : 64'd0);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if (rd_data !== e) begin
                n_fail++;
                $display("FAIL %s rd[%0d]: got %h required %h", tag, i, rd_data, e);
            end
        end
        rd_addr = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d required 0", state); end
        n_checks++; if (count !== '0) begin n_fail++; $display("FAIL rst_count: got %0d required 0", count); end
        n_checks++; if (cycle !== '0) begin n_fail++; $display("FAIL rst_cycle: got %0d required 0", cycle); end
        n_checks++; if ({triggered, timeout} !== 2'b00) begin n_fail++; $display("FAIL rst_flags: got %b required 00", {triggered, timeout}); end
        n_checks++; if (rd_data !== '0) begin n_fail++; $display("FAIL rst_rd_data: got %h required 0", rd_data); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_timeout();
        int edges;
        do_arm(32'd99);
        n_checks++; if (state !== 2'd1 || cycle !== '0) begin n_fail++; $display("FAIL arm: state %0d cycle %0d required 1/0", state, cycle); end
        for (int p = 1; p <= 3; p++) commit(p, 32'h1000_0000 | p);
        n_checks++; if (count !== 5'd3 || state !== 2'd1) begin n_fail++; $display("FAIL to_count3: count %0d state %0d required 3/1", count, state); end
        wait_done(300, edges);
        n_checks++; if (3 + edges != TIMEOUT) begin n_fail++; $display("FAIL to_edge: DONE after %0d cycles, required %0d", 3 + edges, TIMEOUT); end
        n_checks++; if (timeout !== 1'b1 || triggered !== 1'b0) begin n_fail++; $display("FAIL to_flags: timeout %b triggered %b required 1/0", timeout, triggered); end
        n_checks++; if (cycle !== CYC_W'(TIMEOUT)) begin n_fail++; $display("FAIL to_cycle: got %0d required %0d", cycle, TIMEOUT); end
        read_all(4, "timeout");
    endtask

    task automatic test_trigger_window();
        logic [1:0] exp_st;
        do_arm(32'd20);
        for (int p = 0; p < 5; p++) commit(p, 32'hA000_0000 | p);
        rd_addr = '0;
        @(posedge clk); #1;
        n_checks++; if (rd_data !== '0) begin n_fail++; $display("FAIL rd_not_done: got %h required 0", rd_data); end
        for (int p = 5; p < 30; p++) begin
            commit(p, 32'hA000_0000 | p);
            exp_st = (p < 20) ? 2'd1 : (p < 24) ? 2'd2 : 2'd3;
            n_checks++; if (state !== exp_st) begin n_fail++; $display("FAIL win_state pc=%0d: got %0d required %0d", p, state, exp_st); end
        end
        n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL win_count: got %0d required 16", count); end
        n_checks++; if (triggered !== 1'b1 || timeout !== 1'b0) begin n_fail++; $display("FAIL win_flags: triggered %b timeout %b required 1/0", triggered, timeout); end
        read_all(DEPTH, "window");
    endtask

    task automatic test_post_zero();
        do_arm(32'd5);
        commit(32'd5, 32'h0000_0555);
        n_checks++; if (state0 !== 2'd3 || count0 !== 5'd1 || triggered0 !== 1'b1) begin
            n_fail++; $display("FAIL p0_status: state %0d count %0d trig %b required 3/1/1", state0, count0, triggered0);
        end
        rd_addr = '0;
        @(posedge clk); #1;
        n_checks++; if (rd_data0 !== {32'd5, 32'h0000_0555}) begin n_fail++; $display("FAIL p0_rd0: got %h required %h", rd_data0, {32'd5, 32'h0000_0555}); end
    endtask

    task automatic test_trig_on_timeout();
        int n;
        pulse_reset();
        do_arm(32'd77);
        n = 0;
        while (cycle !== CYC_W'(TIMEOUT - 1) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        commit(32'd77, 32'h0000_7777);
        n_checks++; if (state !== 2'd2 || triggered !== 1'b1 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL tt_win: state %0d trig %b timeout %b required 2/1/0", state, triggered, timeout);
        end
        idle(2);
        n_checks++; if (state !== 2'd2 || timeout !== 1'b0) begin n_fail++; $display("FAIL tt_hold: state %0d timeout %b required 2/0", state, timeout); end
    endtask

    task automatic test_reset_mid_post();
        rst_n = 1'b0;
        #2;
        n_checks++; if (state !== 2'd0 || count !== '0 || cycle !== '0 || {triggered, timeout} !== 2'b00) begin
            n_fail++; $display("FAIL mid_rst: state %0d count %0d cycle %0d flags %b required all 0", state, count, cycle, {triggered, timeout});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_arm(32'd1234);
        idle(2);
        n_checks++; if (state !== 2'd1 || cycle !== CYC_W'(2) || count !== '0) begin
            n_fail++; $display("FAIL rearm: state %0d cycle %0d count %0d required 1/2/0", state, cycle, count);
        end
    endtask

    task automatic test_nop();
        int exp_cnt;
        pulse_reset();
        do_arm(32'h40);
        commit(32'h100, 32'h2402_0001);
        commit(32'h104, 32'h0);
        commit(32'h108, 32'h0);
        commit(32'h10c, 32'h0062_1021);
        exp_cnt = FILTER ? 2 : 4;
        n_checks++; if (count !== exp_cnt[AW:0]) begin n_fail++; $display("FAIL nop_count: got %0d required %0d", count, exp_cnt); end
        commit(32'h40, 32'h0);
`ifdef SM_TRACE_FILTER_NOP_EN
        n_checks++; if (triggered !== 1'b0 || state !== 2'd1) begin n_fail++; $display("FAIL nop_trig: trig %b state %0d required 0/1", triggered, state); end
`else
        n_checks++; if (triggered !== 1'b1 || state !== 2'd2) begin n_fail++; $display("FAIL nop_trig: trig %b state %0d required 1/2", triggered, state); end
`endif
        commit(32'h40, 32'h0000_1234);
        for (int p = 0; p < 4; p++) commit(32'h300 + 4 * p, 32'hC000_0000 | p);
        n_checks++; if (state !== 2'd3 || count !== AW'(model_q.size())) begin
            n_fail++; $display("FAIL nop_done: state %0d count %0d required 3/%0d", state, count, model_q.size());
        end
        read_all(9, "nop");
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_trigger_window();
        test_post_zero();
        test_trig_on_timeout();
        test_reset_mid_post();
        test_nop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
